// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: state encoding and bus constants shared by the data-memory bridge
package dmem_bridge_pkg;
    typedef enum logic [1:0] {
        DMB_IDLE = 2'd0,
        DMB_BUSY = 2'd1,
        DMB_DONE = 2'd2
    } dmb_state_e;
    localparam logic [3:0]  BUS_SEL_WORD = 4'hF;
    localparam logic [31:0] DMB_ERR_DATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns MEM-stage loads/stores into single-word req/ack bus cycles
// and stalls the pipeline until each access completes, aborts or is rejected.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DMB_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_dout,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_din,
    input  logic        bus_ack
);
    localparam logic [9:0] LAST = 10'(TIMEOUT - 1);

    dmb_state_e state;
    logic [9:0] cnt;
    logic       req;

    assign req       = mem_valid & (mem_ren | mem_wen);
    assign mem_stall = (state == DMB_IDLE & req) | (state == DMB_BUSY);
    assign bus_sel   = BUS_SEL_WORD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DMB_IDLE;
            bus_cyc  <= 1'b0;
            bus_stb  <= 1'b0;
            bus_we   <= 1'b0;
            bus_addr <= '0;
            bus_dout <= '0;
            mem_din  <= '0;
            mem_err  <= 1'b0;
            cnt      <= '0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                DMB_IDLE: if (req) begin
                    if (mem_addr[1:0] == 2'b00) begin
                        bus_addr <= mem_addr;
                        bus_dout <= mem_dout;
                        bus_we   <= mem_wen;
                        bus_cyc  <= 1'b1;
                        bus_stb  <= 1'b1;
                        cnt      <= '0;
                        state    <= DMB_BUSY;
                    end else begin
                        mem_din <= ERR_DATA;
                        mem_err <= 1'b1;
                        state   <= DMB_DONE;
                    end
                end
                DMB_BUSY: if (bus_ack || cnt == LAST) begin
                    bus_cyc <= 1'b0;
                    bus_stb <= 1'b0;
                    bus_we  <= 1'b0;
                    state   <= DMB_DONE;
                    // a late ack still wins over the timeout in the same cycle
                    if (bus_ack) begin
                        if (!bus_we) mem_din <= bus_din;
                    end else begin
                        mem_din <= ERR_DATA;
                        mem_err <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 10'd1;
                end
                default: state <= DMB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed checks of the data-memory bridge with TIMEOUT=8
module tb_dmem_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic [31:0] mem_addr = '0, mem_dout = '0, bus_din = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] mem_din, bus_addr, bus_dout;
    logic        mem_stall, mem_err, bus_cyc, bus_stb, bus_we;
    logic [3:0]  bus_sel;
    int          errors = 0, checks = 0;

    dmem_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_stall(mem_stall), .mem_err(mem_err),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_sel(bus_sel),
        .bus_din(bus_din), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic request(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_valid = 1'b1; mem_ren = r; mem_wen = w; mem_addr = a; mem_dout = d;
    endtask

    task automatic idle_req();
        mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        @(negedge clk);
        chk("rst_cyc", 32'(bus_cyc), 0);
        chk("rst_din", mem_din, 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_sel", 32'(bus_sel), 32'hF);
        rst_n = 1'b1;
        step();

        // aligned load, ack in first BUSY cycle
        request(1, 0, 32'h10, 0);
        #1 chk("ld_stall0", 32'(mem_stall), 1);
        chk("ld_nocyc", 32'(bus_cyc), 0);
        step();
        chk("ld_cyc", 32'(bus_cyc), 1);
        chk("ld_stb", 32'(bus_stb), 1);
        chk("ld_we", 32'(bus_we), 0);
        chk("ld_addr", bus_addr, 32'h10);
        chk("ld_stall1", 32'(mem_stall), 1);
        bus_ack = 1'b1; bus_din = 32'hDEAD_BEEF;
        step();
        chk("ld_done_stall", 32'(mem_stall), 0);
        chk("ld_din", mem_din, 32'hDEAD_BEEF);
        chk("ld_err", 32'(mem_err), 0);
        chk("ld_done_cyc", 32'(bus_cyc), 0);
        bus_ack = 1'b0; idle_req();
        step();
        chk("ld_idle_stall", 32'(mem_stall), 0);

        // aligned store, three wait states
        request(0, 1, 32'h20, 32'h1234_5678);
        #1 chk("st_stall0", 32'(mem_stall), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("st_cyc", 32'(bus_cyc), 1);
            chk("st_we", 32'(bus_we), 1);
            chk("st_addr", bus_addr, 32'h20);
            chk("st_dout", bus_dout, 32'h1234_5678);
            chk("st_stall", 32'(mem_stall), 1);
        end
        bus_ack = 1'b1; bus_din = 32'h0BAD_0BAD;
        step();
        chk("st_done_stall", 32'(mem_stall), 0);
        chk("st_done_cyc", 32'(bus_cyc), 0);
        chk("st_done_we", 32'(bus_we), 0);
        chk("st_din_hold", mem_din, 32'hDEAD_BEEF);
        chk("st_err", 32'(mem_err), 0);
        bus_ack = 1'b0; idle_req();
        step();

        // misaligned load
        request(1, 0, 32'h13, 0);
        #1 chk("mis_stall0", 32'(mem_stall), 1);
        chk("mis_nocyc0", 32'(bus_cyc), 0);
        step();
        chk("mis_nocyc1", 32'(bus_cyc), 0);
        chk("mis_stall1", 32'(mem_stall), 0);
        chk("mis_err", 32'(mem_err), 1);
        chk("mis_din", mem_din, 32'hFFFF_FFFF);
        idle_req();
        step();
        chk("mis_err_pulse", 32'(mem_err), 0);
        chk("mis_nocyc2", 32'(bus_cyc), 0);

        // back-to-back loads
        request(1, 0, 32'h0, 0);
        step();
        chk("b2b_addr0", bus_addr, 32'h0);
        bus_ack = 1'b1; bus_din = 32'hA5A5_0000;
        step();
        chk("b2b_din0", mem_din, 32'hA5A5_0000);
        chk("b2b_stall0", 32'(mem_stall), 0);
        bus_ack = 1'b0;
        step();
        request(1, 0, 32'h4, 0);
        #1 chk("b2b_stall1", 32'(mem_stall), 1);
        step();
        chk("b2b_cyc1", 32'(bus_cyc), 1);
        chk("b2b_addr1", bus_addr, 32'h4);
        bus_ack = 1'b1; bus_din = 32'h5A5A_1111;
        step();
        chk("b2b_din1", mem_din, 32'h5A5A_1111);
        bus_ack = 1'b0; idle_req();
        step();

        // timeout, no ack
        request(1, 0, 32'h40, 0);
        step();
        n = 0;
        while (bus_cyc && n < 20) begin
            n++;
            step();
        end
        chk("to_cyc_cycles", 32'(n), 8);
        chk("to_err", 32'(mem_err), 1);
        chk("to_din", mem_din, 32'hFFFF_FFFF);
        chk("to_stall", 32'(mem_stall), 0);
        idle_req();
        step();
        chk("to_err_pulse", 32'(mem_err), 0);

        // reset mid-transaction
        request(1, 0, 32'h80, 0);
        step();
        chk("rb_cyc", 32'(bus_cyc), 1);
        #1 rst_n = 1'b0;
        #1 chk("rb_cyc_drop", 32'(bus_cyc), 0);
        chk("rb_stb_drop", 32'(bus_stb), 0);
        chk("rb_din", mem_din, 0);
        idle_req();
        bus_ack = 1'b1; bus_din = 32'h7777_7777;
        step();
        rst_n = 1'b1;
        step();
        chk("rb_late_ack_cyc", 32'(bus_cyc), 0);
        chk("rb_late_ack_din", mem_din, 0);
        chk("rb_stall", 32'(mem_stall), 0);
        bus_ack = 1'b0;

        // flushed instruction
        mem_valid = 1'b0; mem_ren = 1'b1; mem_addr = 32'h100;
        #1 chk("fl_stall0", 32'(mem_stall), 0);
        step();
        chk("fl_cyc", 32'(bus_cyc), 0);
        chk("fl_stall1", 32'(mem_stall), 0);
        idle_req();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
